// File: rtl/integrate_dump_pkg.sv
// rtl/integrate_dump_pkg.sv - shared constant function for sizing the window counter
package integrate_dump_pkg;

    // Ceiling log2, used at elaboration time to size counters.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(v)) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/integrate_dump_sat_add.sv
// rtl/integrate_dump_sat_add.sv - signed adder with wrap or saturate on overflow
//
// Ports:
//   a, b : w-bit signed operands
//   y    : w-bit signed result (wrapped or clamped per sat)
//   ov   : true sum did not fit in w signed bits
module sat_add #(
    parameter int w   = 12,
    parameter int sat = 0
) (
    input  logic [w-1:0] a,
    input  logic [w-1:0] b,
    output logic [w-1:0] y,
    output logic         ov
);

    logic [w:0] sum;
    logic [w-1:0] lim_max;
    logic [w-1:0] lim_min;

    assign sum     = {a[w-1], a} + {b[w-1], b};
    assign lim_max = {1'b0, {(w-1){1'b1}}};
    assign lim_min = {1'b1, {(w-1){1'b0}}};

    // The w+1-bit sum fits in w bits exactly when its top two bits agree.
    assign ov = sum[w] ^ sum[w-1];

    always_comb begin
        y = sum[w-1:0];
        if (ov && (sat != 0)) begin
            // sum[w] is the true sign, so it selects which limit was crossed.
            y = sum[w] ? lim_min : lim_max;
        end
    end

endmodule

// File: rtl/integrate_dump.sv
// rtl/integrate_dump.sv - windowed signed integrate-and-dump with overflow flag
//
// Ports:
//   clk   : rising-edge clock
//   clr_n : asynchronous active-low reset
//   en    : sample qualifier
//   in    : n-bit signed sample
//   out   : m-bit signed window sum, held between dumps
//   stb   : one-cycle pulse after each dump
//   ovf   : overflow seen within the window just dumped
module integrate_dump
    import integrate_dump_pkg::*;
#(
    parameter int n   = 8,
    parameter int m   = 12,
    parameter int d   = 16,
    parameter int sat = 0
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    input  logic [n-1:0] in,
    output logic [m-1:0] out,
    output logic         stb,
    output logic         ovf
);

    localparam int cw = (clog2(d) < 1) ? 1 : clog2(d);
    localparam logic [cw-1:0] last = cw'(d - 1);

    logic [m-1:0]  acc;
    logic [cw-1:0] cnt;
    logic          win_ovf;
    logic [m-1:0]  in_ext;
    logic [m-1:0]  result;
    logic          add_ovf;

    assign in_ext = m'($signed(in));

    sat_add #(
        .w   (m),
        .sat (sat)
    ) u_add (
        .a  (acc),
        .b  (in_ext),
        .y  (result),
        .ov (add_ovf)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            acc     <= '0;
            cnt     <= '0;
            win_ovf <= 1'b0;
            out     <= '0;
            stb     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            stb <= 1'b0;
            if (en) begin
                if (cnt == last) begin
                    // Dump and restart so the next enabled sample opens a new window.
                    out     <= result;
                    ovf     <= win_ovf | add_ovf;
                    stb     <= 1'b1;
                    acc     <= '0;
                    cnt     <= '0;
                    win_ovf <= 1'b0;
                end else begin
                    acc     <= result;
                    cnt     <= cnt + 1'b1;
                    win_ovf <= win_ovf | add_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_integrate_dump.sv
// tb/tb_integrate_dump.sv - randomized and directed checks of integrate_dump against a model
module tb_integrate_dump;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  smp = '0;

    logic [8:0]  out_w, out_s, out_1;
    logic [11:0] out_x;
    logic        stb_w, stb_s, stb_1, stb_x;
    logic        ovf_w, ovf_s, ovf_1, ovf_x;

    always #5 clk = ~clk;

    integrate_dump #(.n(8), .m(9), .d(4), .sat(0)) u_wrap (
        .clk(clk), .clr_n(clr_n), .en(en), .in(smp), .out(out_w), .stb(stb_w), .ovf(ovf_w));
    integrate_dump #(.n(8), .m(9), .d(4), .sat(1)) u_sat (
        .clk(clk), .clr_n(clr_n), .en(en), .in(smp), .out(out_s), .stb(stb_s), .ovf(ovf_s));
    integrate_dump #(.n(8), .m(9), .d(1), .sat(0)) u_d1 (
        .clk(clk), .clr_n(clr_n), .en(en), .in(smp), .out(out_1), .stb(stb_1), .ovf(ovf_1));
    integrate_dump #(.n(8), .m(12), .d(16), .sat(0)) u_dflt (
        .clk(clk), .clr_n(clr_n), .en(en), .in(smp), .out(out_x), .stb(stb_x), .ovf(ovf_x));

    int errs = 0;
    int checks = 0;

    int p_m [4] = '{9, 9, 9, 12};
    int p_d [4] = '{4, 4, 1, 16};
    int p_s [4] = '{0, 1, 0, 0};

    int m_acc [4];
    int m_cnt [4];
    int m_wov [4];
    int m_out [4];
    int m_stb [4];
    int m_ovf [4];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_acc[k] = 0; m_cnt[k] = 0; m_wov[k] = 0;
            m_out[k] = 0; m_stb[k] = 0; m_ovf[k] = 0;
        end
    endtask

    // Window integrator described with plain integer arithmetic.
    task automatic model_step(input int e, input int x);
        int sum, hi, lo, r, o;
        for (int k = 0; k < 4; k++) begin
            m_stb[k] = 0;
            if (e != 0) begin
                hi  = (1 << (p_m[k] - 1)) - 1;
                lo  = -(1 << (p_m[k] - 1));
                sum = m_acc[k] + x;
                o   = (sum > hi || sum < lo) ? 1 : 0;
                r   = sum;
                if (o != 0) begin
                    if (p_s[k] != 0) r = (sum > hi) ? hi : lo;
                    else             r = (sum > hi) ? sum - (1 << p_m[k]) : sum + (1 << p_m[k]);
                end
                if (m_cnt[k] == p_d[k] - 1) begin
                    m_out[k] = r;
                    m_ovf[k] = m_wov[k] | o;
                    m_stb[k] = 1;
                    m_acc[k] = 0; m_cnt[k] = 0; m_wov[k] = 0;
                end else begin
                    m_acc[k] = r;
                    m_cnt[k] = m_cnt[k] + 1;
                    m_wov[k] = m_wov[k] | o;
                end
            end
        end
    endtask

    task automatic check_all(input string ph);
        check({ph, ".wrap.out"}, $signed(out_w), m_out[0]);
        check({ph, ".wrap.stb"}, int'(stb_w), m_stb[0]);
        check({ph, ".wrap.ovf"}, int'(ovf_w), m_ovf[0]);
        check({ph, ".sat.out"},  $signed(out_s), m_out[1]);
        check({ph, ".sat.stb"},  int'(stb_s), m_stb[1]);
        check({ph, ".sat.ovf"},  int'(ovf_s), m_ovf[1]);
        check({ph, ".d1.out"},   $signed(out_1), m_out[2]);
        check({ph, ".d1.stb"},   int'(stb_1), m_stb[2]);
        check({ph, ".d1.ovf"},   int'(ovf_1), m_ovf[2]);
        check({ph, ".dflt.out"}, $signed(out_x), m_out[3]);
        check({ph, ".dflt.stb"}, int'(stb_x), m_stb[3]);
        check({ph, ".dflt.ovf"}, int'(ovf_x), m_ovf[3]);
    endtask

    // Inputs change 1 time unit after the edge; outputs are checked there too.
    task automatic cycle(input string ph, input int e, input int x);
        en  = (e != 0);
        smp = 8'(x);
        @(posedge clk);
        model_step(e, x);
        #1;
        check_all(ph);
    endtask

    task automatic async_reset();
        clr_n = 1'b0;
        #1;
        model_reset();
        check_all("rst");
        @(posedge clk);
        #1;
        clr_n = 1'b1;
    endtask

    int stbs;
    int rx;

    initial begin
        model_reset();
        en = 1'b0;
        smp = '0;
        #2;
        check_all("por");
        @(posedge clk);
        #1;
        clr_n = 1'b1;

        cycle("basic", 1, 33); cycle("basic", 1, -7);
        cycle("basic", 1, -122); cycle("basic", 1, -122);
        check("basic.out", $signed(out_w), -218);
        check("basic.ovf", int'(ovf_w), 0);
        check("basic.stb", int'(stb_w), 1);

        for (int i = 0; i < 3; i++) cycle("wrapwin", 1, 100);
        cycle("wrapwin", 1, 0);
        check("wrap.out", $signed(out_w), -212);
        check("wrap.ovf", int'(ovf_w), 1);
        check("satw.out", $signed(out_s), 255);
        check("satw.ovf", int'(ovf_s), 1);

        for (int i = 0; i < 4; i++) cycle("zeros", 1, 0);
        check("zeros.out", $signed(out_w), 0);
        check("zeros.ovf", int'(ovf_w), 0);

        for (int i = 0; i < 4; i++) cycle("neg", 1, -128);
        check("satneg.out", $signed(out_s), -256);
        check("satneg.ovf", int'(ovf_s), 1);

        cycle("mix", 1, -128); cycle("mix", 1, 127);
        cycle("mix", 1, 0);    cycle("mix", 1, 0);
        check("satmix.out", $signed(out_s), -1);
        check("satmix.ovf", int'(ovf_s), 0);

        stbs = 0;
        for (int s = 0; s < 4; s++) begin
            for (int g = 0; g < s; g++) begin
                cycle("gate", 0, 99);
                stbs += int'(stb_w);
            end
            cycle("gate", 1, 10 * (s + 1));
            stbs += int'(stb_w);
            if (s == 3) check("gate.stb_on_last", int'(stb_w), 1);
        end
        check("gate.out", $signed(out_w), 100);
        cycle("gate", 0, 99);
        stbs += int'(stb_w);
        check("gate.stbs", stbs, 1);

        cycle("d1", 1, 5);
        check("d1.a", $signed(out_1), 5);
        cycle("d1", 1, -3);
        check("d1.b", $signed(out_1), -3);
        cycle("d1", 1, 7);
        check("d1.c", $signed(out_1), 7);
        check("d1.stb", int'(stb_1), 1);
        cycle("d1", 0, 0);
        check("d1.stb_off", int'(stb_1), 0);

        cycle("pre", 1, 50); cycle("pre", 1, 50);
        async_reset();
        for (int i = 0; i < 4; i++) cycle("post", 1, 1);
        check("post.out", $signed(out_w), 4);
        check("post.ovf", int'(ovf_w), 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
            end else begin
                rx = $urandom_range(0, 255) - 128;
                if ($urandom_range(0, 7) == 0) rx = ($urandom_range(0, 1) != 0) ? 127 : -128;
                cycle("rand", ($urandom_range(0, 3) != 0) ? 1 : 0, rx);
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/integrate_dump.md
Name: integrate_dump

Overview:
- Parametrised successor to the free-running signed integrator.
- Accumulates signed samples, qualified by an enable, over a programmable window of d enabled samples.
- At the end of each window it dumps the sum to a registered output with a one-cycle strobe, then restarts from zero.
- Selectable wrap or saturate arithmetic, plus a per-window overflow flag; feeds decimating filters and rate/energy meters.

Parameters:
- n, 8: input sample width, signed two's complement.
- m, 12: accumulator/output width, signed; m >= n required.
- d, 16: window length in enabled samples; d >= 1.
- sat, 0: 0 = wrap on overflow, 1 = saturate at m-bit signed limits.

Ports:
- clk, in, 1: clock, rising edge.
- clr_n, in, 1: reset, asynchronous, active-low.
- en, in, 1: sample qualifier; in is consumed only when en=1.
- in, in, n: signed input sample.
- out, out, m: signed window sum, registered, held between dumps.
- stb, out, 1: one-cycle pulse, high in the cycle after the dump edge.
- ovf, out, 1: overflow occurred in the window just dumped; updated with out.

Behaviour:
- Reset (clr_n=0, asynchronous): acc=0, cnt=0, win_ovf=0, out=0, stb=0, ovf=0.
- On release, the first enabled sample starts window 0.
- Width rule: in is sign-extended to m bits. sum = acc + sext(in), computed in m+1 bits.
- Overflow: overflow = sum outside [-2^(m-1), 2^(m-1)-1].
  - sat=0: result = low m bits of sum.
  - sat=1: result is clamped to the violated limit. Later adds start from the clamped value.
- Each rising edge with en=0: acc, cnt and win_ovf hold; stb <= 0.
- Each rising edge with en=1 and cnt < d-1:
  - acc <= result; cnt <= cnt+1.
  - win_ovf <= win_ovf | overflow; stb <= 0.
- Each rising edge with en=1 and cnt == d-1 (dump):
  - out <= result; ovf <= win_ovf | overflow; stb <= 1.
  - acc <= 0; cnt <= 0; win_ovf <= 0.
- Latency: out and stb are valid one cycle after the edge that consumed the d-th enabled sample.
- Consecutive windows: the next window's first sample may arrive on the cycle after the dump. There are no bubbles and no lost samples.
- d=1: every enabled sample dumps. out = sext(in) and stb follows en delayed by one cycle. ovf is always 0.
- cnt width: max(1, clog2(d)). cnt never exceeds d-1.
- Mid-window reset discards the partial sum. out is cleared to 0; no strobe is produced.
- out, ovf, acc, cnt and win_ovf change only as listed above or on reset. out holds its value indefinitely between dumps.

Decomposition:
- Shared include: clog2 constant function, used to size cnt. No other shared constants or typedefs.
- One sub-module: sat_add.
  - Parameters: w, sat.
  - Inputs: a[w], b[w].
  - Outputs: y[w], ov.
  - Combinational m+1-bit add with wrap/clamp and overflow detect; reused by future accumulator blocks.
- integrate_dump owns the counter, window-overflow register and output registers.

Test Plan:
- Basic window (n=8, m=9, d=4, sat=0): en=1, in = 33, -7, -122, -122 → stb one cycle after 4th sample; out=-218, ovf=0. Next window starts at 0.
- Wrap (n=8, m=9, d=4, sat=0): in = 100, 100, 100, 0 → out=-212 (300-512), ovf=1. Following window of all zeros gives out=0, ovf=0.
- Saturate (sat=1, same stimulus): out=255, ovf=1. Check also in = -128 ×4 → out=-256, ovf=1; then -128, 127, 0, 0 → out=-1, ovf=0.
- Enable gating (d=4): samples 10, 20, 30, 40 with en=0 gaps of 0–3 cycles between them, and in=99 while en=0 → out=100. stb exactly once, one cycle after the edge consuming 40.
- Reset mid-window: 2 samples of 50, then clr_n=0 asynchronously between edges → out=0, stb=0 immediately. After release, 4 samples of 1 → out=4, no residue.
- d=1 and back-to-back: in = 5, -3, 7 on consecutive enabled cycles → out 5, -3, 7 on consecutive cycles. stb held high 3 cycles, then 0.
